// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a scaled sprite from ROM into a framebuffer, skipping transparent and off-screen pixels.
module sprite_blitter #(
    parameter int HWIDTH = 10,
    parameter int VWIDTH = 10,
    parameter int AWIDTH = 12,
    parameter int IWIDTH = 1,
    parameter int HSIZE = 64,
    parameter int VSIZE = 64,
    parameter int SCREEN_H = 640,
    parameter int SCREEN_V = 480,
    parameter int FWIDTH = 19,
    parameter int DWIDTH = 12,
    parameter logic [DWIDTH-1:0] TRANSPARENT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HWIDTH-1:0] hoffset,
    input  logic [VWIDTH-1:0] voffset,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [DWIDTH-1:0] rom_data,
    output logic [FWIDTH-1:0] fb_addr,
    output logic [DWIDTH-1:0] fb_data,
    output logic              fb_we,
    input  logic              fb_ready
);
    localparam int HB = $clog2(HSIZE);
    localparam int VB = $clog2(VSIZE);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;
    state_t state, next;
    logic [HB-1:0] h;
    logic [VB-1:0] v;
    logic [HWIDTH-1:0] hoff;
    logic [VWIDTH-1:0] voff;
    logic [HWIDTH:0] x;
    logic [VWIDTH:0] y;
    logic skip, adv, last_h, last;
    // one extra bit so destinations past the right/bottom edge clip instead of wrapping
    assign x = (HWIDTH+1)'(hoff) + (HWIDTH+1)'(h);
    assign y = (VWIDTH+1)'(voff) + (VWIDTH+1)'(v);
    assign skip = rom_data == TRANSPARENT || 32'(x) >= SCREEN_H || 32'(y) >= SCREEN_V;
    assign adv = (state == WAIT && skip) || (state == WRITE && fb_ready);
    assign last_h = 32'(h) == HSIZE - 1;
    assign last = last_h && 32'(v) == VSIZE - 1;
    assign rom_addr = AWIDTH'(32'(v >> IWIDTH) * (HSIZE >> IWIDTH) + 32'(h >> IWIDTH));
    assign busy = state == FETCH || state == WAIT || state == WRITE;
    assign done = state == DONE;
    assign fb_we = state == WRITE;
    always_comb begin
        next = state;
        unique case (state)
            IDLE:    next = start ? FETCH : IDLE;
            FETCH:   next = WAIT;
            WAIT:    next = skip ? (last ? DONE : FETCH) : WRITE;
            WRITE:   next = fb_ready ? (last ? DONE : FETCH) : WRITE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            h <= '0;
            v <= '0;
            hoff <= '0;
            voff <= '0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            state <= next;
            if (state == IDLE && start) begin
                hoff <= hoffset;
                voff <= voffset;
                h <= '0;
                v <= '0;
            end
            if (adv) begin
                h <= last_h ? '0 : h + 1'b1;
                if (last_h) v <= v + 1'b1;
            end
            if (state == WAIT && !skip) begin
                fb_data <= rom_data;
                fb_addr <= FWIDTH'(32'(y) * SCREEN_H + 32'(x));
            end
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed checks of a 4x4 (2x-scaled) sprite blit against hand-computed framebuffer writes.
module tb_sprite_blitter;
    logic clk = 0, rst = 1, start = 0, fb_ready = 1;
    logic [9:0] hoffset = 0, voffset = 0;
    logic busy, done, fb_we;
    logic [11:0] rom_addr, rom_data = 0, fb_data;
    logic [18:0] fb_addr;
    logic [11:0] rom [16];
    logic [31:0] wa [64], wr [64], wd [64];
    int wcnt = 0, n_cmp = 0, n_bad = 0, cyc, bad;
    sprite_blitter #(.HSIZE(4), .VSIZE(4), .IWIDTH(1)) dut (
        .clk(clk), .rst(rst), .start(start), .hoffset(hoffset), .voffset(voffset),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready));
    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr[3:0]];
    always @(negedge clk)
        if (fb_we && fb_ready && wcnt < 64) begin
            wa[wcnt] = fb_addr;
            wr[wcnt] = rom_addr;
            wd[wcnt] = fb_data;
            wcnt++;
        end
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic start_blit(int ho, int vo);
        @(negedge clk);
        start = 1;
        hoffset = 10'(ho);
        voffset = 10'(vo);
        wcnt = 0;
        @(posedge clk);
        #1 start = 0;
    endtask
    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 400) begin
            @(posedge clk);
            #1 c++;
        end
        check("done_seen", {31'b0, done}, 1);
        check("busy_in_done", {31'b0, busy}, 0);
        @(posedge clk);
        #1 check("done_one_cycle", {31'b0, done}, 0);
    endtask
    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 12'd5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_we", {31'b0, fb_we}, 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        check("rst_fb_data", 32'(fb_data), 0);
        rst = 0;
        start_blit(10, 20);
        check("busy_after_start", {31'b0, busy}, 1);
        wait_done(cyc);
        check("latency", cyc, 48);
        check("a_writes", wcnt, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("a_addr%0d", i), wa[i], 32'((20 + i / 4) * 640 + 10 + i % 4));
            check($sformatf("a_rom%0d", i), wr[i], 32'((i / 8) * 2 + (i % 4) / 2));
        end
        check("a_data", wd[15], 5);
        rom[0] = 12'd0;
        start_blit(10, 20);
        wait_done(cyc);
        check("transp_writes", wcnt, 12);
        check("transp_first", wa[0], 20 * 640 + 12);
        rom[0] = 12'd5;
        start_blit(638, 20);
        wait_done(cyc);
        check("clip_right", wcnt, 8);
        check("clip_right_last", wa[7], 23 * 640 + 639);
        start_blit(10, 478);
        wait_done(cyc);
        check("clip_bottom", wcnt, 8);
        check("clip_bottom_last", wa[7], 479 * 640 + 13);
        start_blit(640, 20);
        wait_done(cyc);
        check("clip_all", wcnt, 0);
        fb_ready = 0;
        start_blit(10, 20);
        cyc = 0;
        while (!fb_we && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_we%0d", i), {31'b0, fb_we}, 1);
            check($sformatf("stall_addr%0d", i), 32'(fb_addr), 20 * 640 + 10);
            check($sformatf("stall_data%0d", i), 32'(fb_data), 5);
            @(posedge clk);
            #1;
        end
        check("stall_no_write", wcnt, 0);
        fb_ready = 1;
        wait_done(cyc);
        check("stall_writes", wcnt, 16);
        start_blit(10, 20);
        cyc = 0;
        while (wcnt < 3 && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        rst = 1;
        start = 1;
        @(posedge clk);
        #1 rst = 0;
        start = 0;
        check("abort_we", {31'b0, fb_we}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 if (done || busy) bad++;
        end
        check("abort_quiet", bad, 0);
        check("abort_writes", wcnt, 3);
        start_blit(10, 20);
        wait_done(cyc);
        check("rerun_writes", wcnt, 16);
        start_blit(10, 20);
        repeat (10) @(posedge clk);
        #1 start = 1;
        hoffset = 100;
        voffset = 100;
        @(posedge clk);
        #1 start = 0;
        wait_done(cyc);
        check("restart_writes", wcnt, 16);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (wa[i] != 32'((20 + i / 4) * 640 + 10 + i % 4)) bad++;
        check("restart_offsets", bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter HWIDTH, default 10, meaning screen horizontal coordinate width.
REQ-002 SHALL have parameter VWIDTH, default 10, meaning screen vertical coordinate width.
REQ-003 SHALL have parameter AWIDTH, default 12, meaning sprite ROM address width.
REQ-004 SHALL have parameter IWIDTH, default 1, meaning scale shift; each sprite texel covers 2^IWIDTH x 2^IWIDTH screen pixels.
REQ-005 SHALL have parameter HSIZE, default 64, meaning scaled sprite width in screen pixels, a multiple of 2^IWIDTH.
REQ-006 SHALL have parameter VSIZE, default 64, meaning scaled sprite height in screen pixels, a multiple of 2^IWIDTH.
REQ-007 SHALL have parameter SCREEN_H, default 640, meaning framebuffer width in pixels.
REQ-008 SHALL have parameter SCREEN_V, default 480, meaning framebuffer height in pixels.
REQ-009 SHALL have parameter FWIDTH, default 19, meaning framebuffer address width.
REQ-010 SHALL have parameter DWIDTH, default 12, meaning pixel data width.
REQ-011 SHALL have parameter TRANSPARENT, default 0, meaning DWIDTH-bit colour that is never written.
REQ-012 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-013 SHALL have ports: start in 1, request a blit; hoffset in HWIDTH, destination left x; voffset in VWIDTH, destination top y.
REQ-014 SHALL have ports: busy out 1, blit in progress; done out 1, one-cycle completion pulse.
REQ-015 SHALL have ports: rom_addr out AWIDTH, sprite ROM address; rom_data in DWIDTH, ROM word, valid exactly 1 cycle after rom_addr.
REQ-016 SHALL have ports: fb_addr out FWIDTH; fb_data out DWIDTH; fb_we out 1, write request; fb_ready in 1, framebuffer accepts write.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT, WRITE, DONE.
REQ-018 IDLE: on start=1, latch hoffset/voffset, clear counters h=0 and v=0, go to FETCH; busy=1 from the next cycle.
REQ-019 FETCH: drive rom_addr = (v>>IWIDTH)*(HSIZE>>IWIDTH) + (h>>IWIDTH), truncated to AWIDTH; go to WAIT.
REQ-020 WAIT: capture rom_data; compute x = hoffset+h, y = voffset+v at HWIDTH+1 and VWIDTH+1 bits, with no wrap.
REQ-021 WAIT: if rom_data==TRANSPARENT, x>=SCREEN_H or y>=SCREEN_V, skip the pixel (advance counters); otherwise go to WRITE.
REQ-022 WRITE: fb_we=1, fb_addr = y*SCREEN_H + x, fb_data = captured texel; hold all three stable until a cycle with fb_ready=1.
REQ-023 Write handshake SHALL complete in the cycle fb_we=1 and fb_ready=1; counters then advance.
REQ-024 Advance: h increments; at h==HSIZE-1, h wraps to 0 and v increments; after h==HSIZE-1 and v==VSIZE-1, go to DONE, else go to FETCH.
REQ-025 DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
REQ-026 start while busy=1 or in DONE SHALL be ignored.
REQ-027 Offsets SHALL be sampled only at start acceptance; later changes have no effect on the running blit.
REQ-028 Throughput: with no skips and fb_ready tied high, 3 cycles per pixel, so HSIZE*VSIZE*3 cycles from start to done.
REQ-029 Fully clipped or fully transparent sprites SHALL still complete with done, issuing zero writes.

Reset
REQ-030 rst=1 SHALL force IDLE with busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_data=0, h=v=0.
REQ-031 rst asserted mid-blit SHALL abort it in the same clock edge; no further write and no done pulse.
REQ-032 rst SHALL take priority over start.

Verification
REQ-033 HSIZE=VSIZE=4, IWIDTH=1, offsets (10,20), ROM all 5, fb_ready=1 -> 16 writes at fb_addr 20*640+10..23*640+13, rom_addr sequence 0,0,1,1,0,0,1,1,2,2,3,3,2,2,3,3; done at cycle 48.
REQ-034 Same sprite, ROM texel 0 = TRANSPARENT -> 4 writes suppressed (h,v in 0..1), 12 writes, done still pulses.
REQ-035 hoffset=638 -> only x=638,639 written (8 writes); voffset=478 -> only y=478,479 written; hoffset=640 -> zero writes, done.
REQ-036 fb_ready low for 5 cycles on the first write -> fb_we, fb_addr and fb_data held constant across the stall; write count unchanged.
REQ-037 rst pulsed after 3 writes -> fb_we=0 next cycle, busy=0, no done; new start then runs a full 16-write blit.
REQ-038 start pulsed again mid-blit with new offsets -> ignored; all writes use the original offsets.
